// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream, built from two line buffers.
// Optional end-of-frame pulse on frame_done when WINDOW_GEN_FRAME_DONE_EN is defined.
module window_gen_3x3 #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pixel_valid,
  input  logic [DATA_WIDTH-1:0]   pixel_in,
  output logic                    window_valid,
`ifdef WINDOW_GEN_FRAME_DONE_EN
  output logic                    frame_done,
`endif
  output logic [9*DATA_WIDTH-1:0] window_out
);

  localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned WIN_W = 9 * DATA_WIDTH;

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  window_valid_q, window_valid_d;
  logic [WIN_W-1:0]      window_out_q, window_out_d;
`ifdef WINDOW_GEN_FRAME_DONE_EN
  logic                  frame_done_q, frame_done_d;
`endif

  // line0 holds the previous row, line1 the row before that
  logic [DATA_WIDTH-1:0] line0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] line1_q [IMG_WIDTH];

  // Two most recent columns of the window; the newest column comes straight from the buffers
  logic [DATA_WIDTH-1:0] hist_q [3][2];
  logic [DATA_WIDTH-1:0] hist_d [3][2];
  logic [DATA_WIDTH-1:0] new_col_c [3];
  logic                  last_col_c;
  logic                  last_row_c;

  always_comb begin
    new_col_c[0] = line1_q[col_q];
    new_col_c[1] = line0_q[col_q];
    new_col_c[2] = pixel_in;
    last_col_c   = (col_q == COL_W'(IMG_WIDTH - 1));
    last_row_c   = (row_q == ROW_W'(IMG_HEIGHT - 1));

    col_d          = col_q;
    row_d          = row_q;
    hist_d         = hist_q;
    window_valid_d = 1'b0;
    window_out_d   = window_out_q;
`ifdef WINDOW_GEN_FRAME_DONE_EN
    frame_done_d   = 1'b0;
`endif

    if (pixel_valid) begin
      if (last_col_c) begin
        col_d = '0;
        row_d = last_row_c ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      for (int r = 0; r < 3; r++) begin
        hist_d[r][0] = hist_q[r][1];
        hist_d[r][1] = new_col_c[r];
      end

      // Only full windows inside one row of one frame are emitted
      if ((row_q >= ROW_W'(2)) && (col_q >= COL_W'(2))) begin
        window_valid_d = 1'b1;
        for (int r = 0; r < 3; r++) begin
          window_out_d[DATA_WIDTH*(3*r+0) +: DATA_WIDTH] = hist_q[r][0];
          window_out_d[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] = hist_q[r][1];
          window_out_d[DATA_WIDTH*(3*r+2) +: DATA_WIDTH] = new_col_c[r];
        end
`ifdef WINDOW_GEN_FRAME_DONE_EN
        frame_done_d = last_col_c && last_row_c;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q          <= '0;
      row_q          <= '0;
      window_valid_q <= 1'b0;
      window_out_q   <= '0;
`ifdef WINDOW_GEN_FRAME_DONE_EN
      frame_done_q   <= 1'b0;
`endif
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      window_valid_q <= window_valid_d;
      window_out_q   <= window_out_d;
`ifdef WINDOW_GEN_FRAME_DONE_EN
      frame_done_q   <= frame_done_d;
`endif
    end
  end

  // Buffer contents need no reset: stale entries are overwritten before row 2 of any frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= hist_d;
      if (pixel_valid) begin
        line1_q[col_q] <= line0_q[col_q];
        line0_q[col_q] <= pixel_in;
      end
    end
  end

  assign window_valid = window_valid_q;
  assign window_out   = window_out_q;
`ifdef WINDOW_GEN_FRAME_DONE_EN
  assign frame_done   = frame_done_q;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on a 4x4 image: directed frames plus randomized traffic.
module tb_window_gen_3x3;

  localparam int unsigned DW    = 16;
  localparam int unsigned W     = 4;
  localparam int unsigned H     = 4;
  localparam int unsigned WIN_W = 9 * DW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pixel_valid = 1'b0;
  logic [DW-1:0]    pixel_in = '0;
  logic             window_valid;
  logic [WIN_W-1:0] window_out;
`ifdef WINDOW_GEN_FRAME_DONE_EN
  logic             frame_done;
`endif

  window_gen_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .window_valid (window_valid),
`ifdef WINDOW_GEN_FRAME_DONE_EN
    .frame_done   (frame_done),
`endif
    .window_out   (window_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIN_W-1:0] win;
    int               due;
    bit               last;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIN_W-1:0] log_q[$];
  int               errors = 0;
  int               checks = 0;

  // Reference model: remembers the current frame as an image and its raster position
  logic [DW-1:0] img [H][W];
  int            m_row = 0;
  int            m_col = 0;

  function automatic logic [WIN_W-1:0] model_window(input int r0, input int c0);
    logic [WIN_W-1:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[DW*(3*r+c) +: DW] = img[r0-2+r][c0-2+c];
    return w;
  endfunction

  task automatic model_accept(input logic [DW-1:0] p);
    exp_t e;
    img[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      e.win  = model_window(m_row, m_col);
      e.due  = cyc;
      e.last = (m_row == H-1) && (m_col == W-1);
      exp_q.push_back(e);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row + 1) % H;
    end
  endtask

  task automatic send(input logic [DW-1:0] p, input bit v);
    pixel_in    = p;
    pixel_valid = v;
    @(posedge clk); #1;
    if (v) model_accept(p);
    pixel_valid = 1'b0;
  endtask

  task automatic do_reset(input bit with_pixel);
    reset       = 1'b1;
    pixel_valid = with_pixel;
    pixel_in    = 16'h0063;
    @(posedge clk); #1;
    reset       = 1'b0;
    pixel_valid = 1'b0;
    m_row = 0;
    m_col = 0;
    checks++;
    if (window_valid !== 1'b0 || window_out !== '0) begin
      errors++;
      $display("FAIL reset_state: window_valid=%b window_out=%h, required 0 and 0", window_valid, window_out);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(16'hdead, 1'b0);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_win(input string name, input int idx, input int base);
    logic [WIN_W-1:0] req;
    int               vals[9];
    vals = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int i = 0; i < 9; i++) req[DW*i +: DW] = DW'(vals[i] + base);
    checks++;
    if (idx >= log_q.size() || log_q[idx] !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, (idx < log_q.size()) ? log_q[idx] : '0, req);
    end
  endtask

  task automatic check_centres(input string name);
    int req[4];
    req = '{5, 6, 9, 10};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_q.size() || int'(log_q[i][DW*4 +: DW]) != req[i]) begin
        errors++;
        $display("FAIL %s[%0d]: got centre %0d, required %0d", name, i,
                 (i < log_q.size()) ? int'(log_q[i][DW*4 +: DW]) : -1, req[i]);
      end
    end
  endtask

  // Monitor: every presented window must match the queue head in value and cycle
  always @(negedge clk) begin
    bit fd_exp;
    fd_exp = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_window: no window at cycle %0d, required %h", exp_q[0].due, exp_q[0].win);
      void'(exp_q.pop_front());
    end
    if (window_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        errors++;
        $display("FAIL unexpected_window: got %h at cycle %0d, required none", window_out, cyc);
      end else begin
        fd_exp = exp_q[0].last;
        if (window_out !== exp_q[0].win) begin
          errors++;
          $display("FAIL window_data: got %h, required %h", window_out, exp_q[0].win);
        end
        void'(exp_q.pop_front());
      end
      log_q.push_back(window_out);
    end
`ifdef WINDOW_GEN_FRAME_DONE_EN
    checks++;
    if (frame_done !== fd_exp) begin
      errors++;
      $display("FAIL frame_done: got %b at cycle %0d, required %b", frame_done, cyc, fd_exp);
    end
`endif
  end

  initial begin
    int rst_at;
    int accepted;

    @(posedge clk); #1;
    do_reset(1'b0);

    // Contiguous frame 0..15
    log_q.delete();
    for (int k = 0; k < 16; k++) send(DW'(k), 1'b1);
    idle(3);
    check_int("window_count", log_q.size(), 4);
    check_win("first_window", 0, 0);
    check_centres("centres");

    // Gapped frame
    log_q.delete();
    for (int k = 0; k < 16; k++) begin
      send(DW'(k), 1'b1);
      send(16'hbeef, 1'b0);
    end
    idle(3);
    check_int("gapped_count", log_q.size(), 4);
    check_centres("gapped_centres");

    // Back-to-back frames
    log_q.delete();
    for (int k = 0; k < 32; k++) send(DW'(k), 1'b1);
    idle(3);
    check_int("b2b_count", log_q.size(), 8);
    check_win("b2b_second_first", 4, 16);

    // Mid-frame reset after pixel 6
    log_q.delete();
    for (int k = 0; k < 7; k++) send(DW'(100 + k), 1'b1);
    do_reset(1'b0);
    for (int k = 0; k < 16; k++) send(DW'(k), 1'b1);
    idle(3);
    check_int("midreset_count", log_q.size(), 4);
    check_win("midreset_first", 0, 0);

    // Reset coinciding with a valid pixel discards it
    log_q.delete();
    for (int k = 0; k < 5; k++) send(DW'(200 + k), 1'b1);
    do_reset(1'b1);
    for (int k = 0; k < 16; k++) send(DW'(k), 1'b1);
    idle(3);
    check_int("reset_with_pixel_count", log_q.size(), 4);
    check_win("reset_with_pixel_first", 0, 0);

    // Random traffic with one random mid-frame reset
    log_q.delete();
    rst_at   = 16 + int'($urandom_range(1, 14));
    accepted = 0;
    while (accepted < 6 * 16) begin
      if ($urandom_range(0, 99) < 70) begin
        send(DW'($urandom), 1'b1);
        accepted++;
        if (accepted == rst_at) do_reset(1'b0);
      end else begin
        send(DW'($urandom), 1'b0);
      end
    end
    idle(4);
    check_int("random_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the width of one pixel word; this is the Q2.14 fixed-point pixel from the pixel-to-FP converter.
REQ-002 SHALL have parameter IMG_WIDTH, default 28, giving pixels per row.
REQ-003 SHALL have parameter IMG_HEIGHT, default 28, giving rows per frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pixel_valid, input, 1 bit: pixel_in is accepted on this cycle.
REQ-007 SHALL have port pixel_in, input, DATA_WIDTH bits: raster-order pixel, row-major, no gaps inside a frame except where pixel_valid=0.
REQ-008 SHALL have port window_valid, output, 1 bit: window_out holds a complete 3x3 window this cycle.
REQ-009 SHALL have port window_out, output, 9*DATA_WIDTH bits: the packed 3x3 window.
REQ-010 SHALL have port frame_done, output, 1 bit, present only under the macro in REQ-031: one-cycle end-of-frame pulse.

Function
REQ-011 SHALL hold two line buffers, each IMG_WIDTH deep, plus a 3x3 register window; RAM or register implementation is free.
REQ-012 SHALL track col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) for the next accepted pixel.
REQ-013 SHALL advance col on each cycle with pixel_valid=1; when col=IMG_WIDTH-1 it wraps to 0 and row increments.
REQ-014 SHALL wrap row to 0 after it reaches IMG_HEIGHT-1 with col=IMG_WIDTH-1; the next pixel starts a new frame with no idle cycle required.
REQ-015 SHALL leave all state unchanged on cycles with pixel_valid=0, with window_valid=0.
REQ-016 SHALL pack window_out[DATA_WIDTH*(3*r+c) +: DATA_WIDTH] as the pixel at (row-2+r, col-2+c), where (row, col) is the position of the pixel just accepted; r=0 is the oldest row and c=0 the oldest column.
REQ-017 SHALL assert window_valid for exactly one cycle, in the cycle after accepting a pixel with row>=2 and col>=2; latency is 1 clock.
REQ-018 SHALL NOT assert window_valid for any window that straddles a row boundary or a frame boundary.
REQ-019 SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-020 SHALL hold window_out stable whenever window_valid=0; its value is then don't-care to consumers.
REQ-021 SHALL pass pixel data unmodified, with no arithmetic and no truncation.
REQ-022 SHALL apply no backpressure; the downstream stage must accept a window on every cycle it is offered.

Reset
REQ-023 SHALL, with reset=1 at a clock edge, set col=0, row=0, window_valid=0, window_out=0 and frame_done=0.
REQ-024 SHALL give reset priority over pixel_valid in the same cycle; that pixel is discarded.
REQ-025 SHALL NOT require line-buffer contents to be cleared; stale data must never reach a valid window because of REQ-018.
REQ-026 SHALL, after a mid-frame reset, treat the first accepted pixel as (0,0) of a new frame.

Configuration
REQ-030 SHALL have exactly one compile option, the macro WINDOW_GEN_FRAME_DONE_EN.
REQ-031 SHALL, with WINDOW_GEN_FRAME_DONE_EN defined, provide port frame_done and pulse it high for one cycle in the same cycle as the last window_valid of each frame.
REQ-032 SHALL, without WINDOW_GEN_FRAME_DONE_EN, omit the frame_done port and its logic entirely; all other behaviour is identical.

Verification
(All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4 and pixel k = k for k=0..15, sent with pixel_valid=1 every cycle unless stated otherwise.)
REQ-040 SHALL check the first window: after pixel 10 is accepted -> window_valid=1 on the next cycle with window_out = {0,1,2,4,5,6,8,9,10} (index 0 to index 8).
REQ-041 SHALL check window count: a full frame -> exactly 4 windows, with centres 5, 6, 9 and 10, and no window after pixels 8, 9, 12 or 13.
REQ-042 SHALL check gapped input: the frame with pixel_valid toggling 1,0,1,0 -> the same 4 windows in the same order, each one cycle after its source pixel.
REQ-043 SHALL check back-to-back frames: two frames, the second with pixel k = k+16 -> second frame's first window = {16,17,18,20,21,22,24,25,26}.
REQ-044 SHALL check reset mid-frame: reset after pixel 6, then a full frame -> no window before the new pixel 10, then the normal 4 windows.
REQ-045 SHALL check frame_done with the macro defined: frame_done=1 only in the cycle that outputs the window ending at pixel 15.
